// File: rtl/band_power_window_pkg.sv
// Shared types and width helpers for the beta-band power window and its
// reusable square stage.
package band_power_window_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } bpw_state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int WIN_LOG2_DEF = 8;
  localparam int SQ_W         = 2 * DATA_W_DEF;
  localparam int ACC_W        = SQ_W + WIN_LOG2_DEF;
  localparam int HOLD_MAX     = 15;
  localparam int HOLD_W       = 4;

  function automatic int sq_width(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int acc_width(input int data_w, input int win_log2);
    return sq_width(data_w) + win_log2;
  endfunction

endpackage

// File: rtl/band_power_window_if.sv
// Sample-in / power-out bundle between the band filter, the power window
// and the downstream detector.
interface band_power_window_if #(
  parameter int DATA_W = 32
);
  // Valid-only streaming, no backpressure: the producer presents x with
  // in_valid for exactly one cycle per sample and the consumer must take it;
  // out_valid is a one-cycle pulse and power/above_thresh/alarm hold between
  // pulses. enable and thresh are level controls.
  logic                       enable;
  logic                       in_valid;
  logic signed [DATA_W-1:0]   x;
  logic        [2*DATA_W-1:0] thresh;
  logic                       out_valid;
  logic        [2*DATA_W-1:0] power;
  logic                       above_thresh;
  logic                       alarm;

  modport master (
    output enable, in_valid, x, thresh,
    input  out_valid, power, above_thresh, alarm
  );

  modport slave (
    input  enable, in_valid, x, thresh,
    output out_valid, power, above_thresh, alarm
  );
endinterface

// File: rtl/band_power_window_square_pipe.sv
// Two-stage register-and-square pipeline with valid pass-through and a
// synchronous flush; shared by all band channels.
module band_power_window_square_pipe #(
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   x,
  output logic                       sq_valid,
  output logic        [2*DATA_W-1:0] sq
);

  logic                       v1;
  logic signed [DATA_W-1:0]   x_r;
  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] prod;

  // Full-width signed product; the most negative input squares to 2^(2W-2),
  // which is still positive in 2W bits.
  assign x_ext = {{DATA_W{x_r[DATA_W-1]}}, x_r};
  assign prod  = x_ext * x_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1       <= 1'b0;
      sq_valid <= 1'b0;
      x_r      <= '0;
      sq       <= '0;
    end else begin
      if (in_valid) x_r <= x;
      if (v1)       sq  <= unsigned'(prod);
      if (flush) begin
        v1       <= 1'b0;
        sq_valid <= 1'b0;
      end else begin
        v1       <= in_valid;
        sq_valid <= v1;
      end
    end
  end

endmodule

// File: rtl/band_power_window.sv
// Mean beta-band power over tumbling sample-counted windows, with start-up
// warm-up discard, strict threshold compare and sustained-activity alarm.
module band_power_window
  import band_power_window_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int SKIP_WIN = 2,
  parameter int HOLD_WIN = 3
) (
  input  logic                clk,
  input  logic                reset,
  band_power_window_if.slave  bus,
  output bpw_state_t          state_dbg
);

  localparam int SQ_BITS  = sq_width(DATA_W);
  localparam int ACC_BITS = acc_width(DATA_W, WIN_LOG2);
  localparam int WC_W     = (SKIP_WIN > 1) ? $clog2(SKIP_WIN) : 1;

  bpw_state_t          state, state_next;
  logic                active;
  logic                flush;
  logic                sq_valid;
  logic [SQ_BITS-1:0]  sq;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic [WC_W-1:0]     win_cnt;
  logic [HOLD_W-1:0]   hold;
  logic [HOLD_W-1:0]   hold_next;
  logic                close;
  logic [SQ_BITS-1:0]  power_next;
  logic                above_next;

  assign state_dbg = state;
  assign active    = (state != IDLE);
  // Dropping enable discards in-flight samples immediately, not one cycle late.
  assign flush     = !active || !bus.enable;

  band_power_window_square_pipe #(.DATA_W(DATA_W)) u_square (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (bus.in_valid),
    .x        (bus.x),
    .sq_valid (sq_valid),
    .sq       (sq)
  );

  assign close      = active && bus.enable && sq_valid && (cnt == '1);
  assign acc_sum    = acc + ACC_BITS'(sq);
  assign power_next = acc_sum[ACC_BITS-1:WIN_LOG2];
  assign above_next = (power_next > bus.thresh);
  assign hold_next  = !above_next ? '0 :
                      (hold == HOLD_W'(HOLD_MAX)) ? hold : hold + HOLD_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.enable) state_next = (SKIP_WIN == 0) ? RUN : WARMUP;
      end
      WARMUP: begin
        if (!bus.enable)
          state_next = IDLE;
        else if (close && (win_cnt == WC_W'(SKIP_WIN - 1)))
          state_next = RUN;
      end
      RUN: begin
        if (!bus.enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc              <= '0;
      cnt              <= '0;
      win_cnt          <= '0;
      hold             <= '0;
      bus.out_valid    <= 1'b0;
      bus.power        <= '0;
      bus.above_thresh <= 1'b0;
      bus.alarm        <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (flush) begin
        // power and above_thresh are deliberately kept across a stop.
        acc       <= '0;
        cnt       <= '0;
        win_cnt   <= '0;
        hold      <= '0;
        bus.alarm <= 1'b0;
      end else if (sq_valid) begin
        cnt <= cnt + WIN_LOG2'(1);
        if (close) begin
          acc <= '0;
          if (state == WARMUP) begin
            win_cnt <= win_cnt + WC_W'(1);
          end else begin
            bus.out_valid    <= 1'b1;
            bus.power        <= power_next;
            bus.above_thresh <= above_next;
            hold             <= hold_next;
            bus.alarm        <= (hold_next >= HOLD_W'(HOLD_WIN));
          end
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_band_power_window.sv
// Directed bench for band_power_window: a window-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_band_power_window;
  import band_power_window_pkg::*;

  localparam int WL   = 2;
  localparam int SKIP = 1;
  localparam int HOLD = 2;
  localparam int WIN  = 1 << WL;
  localparam logic [63:0] P62 = 64'h4000_0000_0000_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  bpw_state_t state_dbg, state_dbg8;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       started = 1'b0;

  band_power_window_if #(.DATA_W(32)) bif ();
  band_power_window_if #(.DATA_W(32)) bif8 ();

  band_power_window #(.DATA_W(32), .WIN_LOG2(WL), .SKIP_WIN(SKIP), .HOLD_WIN(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .state_dbg (state_dbg)
  );

  band_power_window #(.DATA_W(32), .WIN_LOG2(8), .SKIP_WIN(2), .HOLD_WIN(3)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif8),
    .state_dbg (state_dbg8)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] sq;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [65:0] win_sum;
  int          win_n, win_idx, m_hold;
  logic        prev_en;
  logic        exp_ov, exp_ab, exp_al;
  logic [63:0] exp_pw;

  function automatic logic [63:0] square(input logic signed [31:0] v);
    longint t;
    t = v;
    return 64'(t * t);
  endfunction

  // A sample counts if the block was already running when it arrived and
  // enable stays high until it reaches the accumulator two edges later.
  always @(posedge clk) begin
    cyc++;
    exp_ov = 1'b0;
    if (reset) begin
      pend_q.delete();
      win_sum = '0; win_n = 0; win_idx = 0; m_hold = 0;
      exp_pw = '0; exp_ab = 1'b0; exp_al = 1'b0;
      prev_en = 1'b0;
      started = 1'b1;
    end else begin
      if (!bif.enable) begin
        pend_q.delete();
        win_sum = '0; win_n = 0; win_idx = 0; m_hold = 0;
        exp_al = 1'b0;
      end else begin
        if (prev_en && bif.in_valid)
          pend_q.push_back('{sq: square(bif.x), due: cyc + 2});
        while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          win_sum += 66'(pend_q[0].sq);
          win_n++;
          void'(pend_q.pop_front());
          if (win_n == WIN) begin
            if (win_idx >= SKIP) begin
              exp_ov = 1'b1;
              exp_pw = 64'(win_sum / 66'(WIN));
              exp_ab = (exp_pw > bif.thresh);
              m_hold = exp_ab ? ((m_hold < 15) ? m_hold + 1 : 15) : 0;
              exp_al = (m_hold >= HOLD);
              exp_q.push_back(exp_pw);
            end
            win_idx++;
            win_sum = '0;
            win_n = 0;
          end
        end
      end
      prev_en = bif.enable;
    end
  end

  // ---------------- compare / monitor ----------------
  logic [63:0] obs_pw[$];
  logic        obs_ab[$], obs_al[$];
  int          obs_cyc[$];
  logic [63:0] obs8_pw[$];
  logic        obs8_ab[$];

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", bif.out_valid, exp_ov);
      chk("power", bif.power, exp_pw);
      chk("above_thresh", bif.above_thresh, exp_ab);
      chk("alarm", bif.alarm, exp_al);
      if (bif.out_valid === 1'b1) begin
        obs_pw.push_back(bif.power);
        obs_ab.push_back(bif.above_thresh);
        obs_al.push_back(bif.alarm);
        obs_cyc.push_back(cyc);
      end
      if (bif8.out_valid === 1'b1) begin
        obs8_pw.push_back(bif8.power);
        obs8_ab.push_back(bif8.above_thresh);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic iv, input logic signed [31:0] xv);
    @(negedge clk);
    bif.enable   = en;
    bif.in_valid = iv;
    bif.x        = xv;
  endtask

  task automatic drive8(input logic en, input logic iv, input logic signed [31:0] xv);
    @(negedge clk);
    bif8.enable   = en;
    bif8.in_valid = iv;
    bif8.x        = xv;
  endtask

  task automatic restart(input logic [63:0] th);
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    bif.thresh = th;
    drive(1'b1, 1'b0, 0);
  endtask

  task automatic clear_obs();
    obs_pw.delete(); obs_ab.delete(); obs_al.delete(); obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_pulse(input string tag, input int k, input logic [63:0] pw,
                             input logic ab, input logic al);
    if (obs_pw.size() > k) begin
      chk({tag, "_power"}, obs_pw[k], pw);
      chk({tag, "_above"}, obs_ab[k], ab);
      chk({tag, "_alarm"}, obs_al[k], al);
    end else begin
      chk({tag, "_dut_pulse_missing"}, obs_pw.size(), k + 1);
    end
    if (exp_q.size() > k) chk({tag, "_model_power"}, exp_q[k], pw);
    else                  chk({tag, "_model_pulse_missing"}, exp_q.size(), k + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s8;
    logic signed [31:0] xmin;
    xmin = 32'sh8000_0000;
    s8 = 0;
    bif.enable = 1'b0;  bif.in_valid = 1'b0;  bif.x = '0;  bif.thresh = '0;
    bif8.enable = 1'b0; bif8.in_valid = 1'b0; bif8.x = '0; bif8.thresh = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_power", bif.power, 64'd0);
    chk("rst_out_valid", bif.out_valid, 1'b0);
    chk("rst_alarm", bif.alarm, 1'b0);
    chk("rst_above", bif.above_thresh, 1'b0);
    chk("rst_state", state_dbg, IDLE);
    chk("rst8_power", bif8.power, 64'd0);
    chk("rst8_state", state_dbg8, IDLE);

    // enable with no samples: nothing may come out
    repeat (10) drive(1'b1, 1'b0, 0);
    chk("idle_run_pulses", obs_pw.size(), 0);
    chk("idle_run_power", bif.power, 64'd0);

    // constant 1000, thresh 0; the sample on the enable-rise cycle is ignored
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    clear_obs();
    bif.thresh = 64'd0;
    drive(1'b1, 1'b1, 5000);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b1, 1000);
      if (i == 8) s8 = cyc + 1;
    end
    repeat (4) drive(1'b1, 1'b0, 0);
    chk("const_pulse_count", obs_pw.size(), 3);
    check_pulse("const_w0", 0, 64'd1000000, 1'b1, 1'b0);
    check_pulse("const_w1", 1, 64'd1000000, 1'b1, 1'b1);
    check_pulse("const_w2", 2, 64'd1000000, 1'b1, 1'b1);
    if (obs_cyc.size() > 0) chk("const_first_latency", obs_cyc[0] - s8, 2);

    // +3/-3 on every other cycle, thresh 9 (strict compare)
    restart(64'd9);
    clear_obs();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, (i % 2 == 0) ? 32'sd3 : -32'sd3);
      drive(1'b1, 1'b0, 0);
    end
    repeat (4) drive(1'b1, 1'b0, 0);
    chk("alt_pulse_count", obs_pw.size(), 2);
    check_pulse("alt_w0", 0, 64'd9, 1'b0, 1'b0);
    check_pulse("alt_w1", 1, 64'd9, 1'b0, 1'b0);

    // powers 100,100,50,100,100 against 99
    restart(64'd99);
    clear_obs();
    repeat (4) drive(1'b1, 1'b1, 10);
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 4; i++)
        drive(1'b1, 1'b1, (w == 2 && i >= 2) ? 32'sd0 : 32'sd10);
    end
    repeat (4) drive(1'b1, 1'b0, 0);
    chk("seq_pulse_count", obs_pw.size(), 5);
    check_pulse("seq_w0", 0, 64'd100, 1'b1, 1'b0);
    check_pulse("seq_w1", 1, 64'd100, 1'b1, 1'b1);
    check_pulse("seq_w2", 2, 64'd50,  1'b0, 1'b0);
    check_pulse("seq_w3", 3, 64'd100, 1'b1, 1'b0);
    check_pulse("seq_w4", 4, 64'd100, 1'b1, 1'b1);

    // stop mid-window with alarm up, then restart with warm-up
    clear_obs();
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
    repeat (4) drive(1'b0, 1'b0, 0);
    chk("stop_no_pulse", obs_pw.size(), 0);
    chk("stop_alarm", bif.alarm, 1'b0);
    chk("stop_power_kept", bif.power, 64'd100);
    chk("stop_state", state_dbg, IDLE);
    bif.thresh = 64'd0;
    drive(1'b1, 1'b0, 0);
    repeat (8) drive(1'b1, 1'b1, 7);
    repeat (4) drive(1'b1, 1'b0, 0);
    chk("rerun_pulse_count", obs_pw.size(), 1);
    check_pulse("rerun_w0", 0, 64'd49, 1'b1, 1'b0);

    // most negative input over 256-sample windows: 2^62, no wrap
    drive8(1'b1, 1'b0, 0);
    repeat (768) drive8(1'b1, 1'b1, xmin);
    repeat (4) drive8(1'b1, 1'b0, 0);
    bif8.thresh = P62;
    repeat (256) drive8(1'b1, 1'b1, xmin);
    repeat (4) drive8(1'b1, 1'b0, 0);
    chk("min8_pulse_count", obs8_pw.size(), 2);
    if (obs8_pw.size() == 2) begin
      chk("min8_w0_power", obs8_pw[0], P62);
      chk("min8_w0_above", obs8_ab[0], 1'b1);
      chk("min8_w1_power", obs8_pw[1], P62);
      chk("min8_w1_above_equal", obs8_ab[1], 1'b0);
    end
    chk("min8_alarm", bif8.alarm, 1'b0);
    chk("min8_state", state_dbg8, RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
